// File: rtl/gate_chk_pkg.sv
// Shared types and reference truth tables for the 2-input gate truth-table checker.
// Truth-table bit i is the expected gate output for vector index i = {a,b}.
package gate_chk_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      FIN    = 3'd4
   } state_t;

   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/chk_settle_timer.sv
// Loadable down-counter that times the settle interval between driving a vector and sampling it.
// The counter holds at zero; expire is asserted whenever the count is zero.
module chk_settle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         expire
);

   logic [W-1:0] value_r;

   // Count register: load has priority, otherwise decrement toward zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_r <= {W{1'b0}};
      end else if (load) begin
         value_r <= load_val;
      end else if (value_r != {W{1'b0}}) begin
         value_r <= value_r - W'(1);
      end else begin
         value_r <= value_r;
      end
   end

   assign value  = value_r;
   assign expire = (value_r == {W{1'b0}});

endmodule

// File: rtl/gate_truth_table_checker.sv
// Sweeps all four input vectors of a 2-input gate, samples its output after a settle
// interval, and compares against EXP_TABLE. Reports pass/fail, mismatch count, first failure.
module gate_truth_table_checker
   import gate_chk_pkg::*;
#(
   parameter logic [3:0] EXP_TABLE  = TT_AND,
   parameter int         SETTLE_CYC = 2,
   parameter int         NUM_PASSES = 1,
   parameter int         ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             dut_a,
   output logic             dut_b,
   input  logic             dut_c,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic             first_fail_valid,
   output logic [1:0]       first_fail_idx
);

   if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
      $error("gate_truth_table_checker: SETTLE_CYC must be in 1..15");
   end
   if (NUM_PASSES < 1 || NUM_PASSES > 255) begin : g_bad_passes
      $error("gate_truth_table_checker: NUM_PASSES must be in 1..255");
   end

   localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC - 1);
   localparam logic [7:0]       PASS_LAST   = 8'(NUM_PASSES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

   state_t           state_r, state_s;
   logic [1:0]       idx_r, idx_inc_s;
   logic [7:0]       pass_cnt_r;
   logic [ERR_W-1:0] err_cnt_r, err_nxt_s;
   logic             ff_valid_r;
   logic [1:0]       ff_idx_r;
   logic             pass_r, busy_r, done_r, dut_a_r, dut_b_r;
   logic             mismatch_s, last_s, start_acc_s;
   logic             timer_exp_s;
   logic [3:0]       timer_unused_s;

   chk_settle_timer #(.W(4)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state_r == DRIVE),
      .load_val (SETTLE_LOAD),
      .value    (timer_unused_s),
      .expire   (timer_exp_s)
   );

   assign idx_inc_s   = idx_r + 2'd1;
   assign start_acc_s = (state_r == IDLE) && start;
   assign last_s      = (idx_r == 2'd3) && (pass_cnt_r == PASS_LAST);

   // Next-state decode for the sweep sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    if (start) state_s = DRIVE; else state_s = IDLE;
         DRIVE:   state_s = SETTLE;
         SETTLE:  if (timer_exp_s) state_s = SAMPLE; else state_s = SETTLE;
         SAMPLE:  if (last_s) state_s = FIN; else state_s = DRIVE;
         FIN:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Mismatch detect and saturating error count; case-inequality flags X/Z in simulation.
   always_comb begin
      mismatch_s = 1'b0;
      err_nxt_s  = err_cnt_r;
      if (state_r == SAMPLE) begin
         mismatch_s = (dut_c !== EXP_TABLE[idx_r]);
      end else begin
         mismatch_s = 1'b0;
      end
      if (start_acc_s) begin
         err_nxt_s = {ERR_W{1'b0}};
      end else if (mismatch_s && (err_cnt_r != ERR_MAX)) begin
         err_nxt_s = err_cnt_r + ERR_W'(1);
      end else begin
         err_nxt_s = err_cnt_r;
      end
   end

   // State, vector counter, drive registers and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         idx_r      <= 2'd0;
         pass_cnt_r <= 8'd0;
         err_cnt_r  <= {ERR_W{1'b0}};
         ff_valid_r <= 1'b0;
         ff_idx_r   <= 2'd0;
         pass_r     <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         dut_a_r    <= 1'b0;
         dut_b_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         err_cnt_r <= err_nxt_s;
         busy_r    <= (state_s == DRIVE) || (state_s == SETTLE) || (state_s == SAMPLE);
         done_r    <= (state_s == FIN);
         case (state_r)
            IDLE: begin
               if (start) begin
                  idx_r      <= 2'd0;
                  pass_cnt_r <= 8'd0;
                  pass_r     <= 1'b0;
                  ff_valid_r <= 1'b0;
                  ff_idx_r   <= 2'd0;
                  dut_a_r    <= 1'b0;
                  dut_b_r    <= 1'b0;
               end
            end
            SAMPLE: begin
               if (mismatch_s && !ff_valid_r) begin
                  ff_valid_r <= 1'b1;
                  ff_idx_r   <= idx_r;
               end
               // Pass verdict uses the count including this final sample.
               if (last_s) begin
                  pass_r <= (err_nxt_s == {ERR_W{1'b0}});
               end else begin
                  idx_r   <= idx_inc_s;
                  dut_a_r <= idx_inc_s[1];
                  dut_b_r <= idx_inc_s[0];
                  if (idx_r == 2'd3) begin
                     pass_cnt_r <= pass_cnt_r + 8'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign dut_a            = dut_a_r;
   assign dut_b            = dut_b_r;
   assign busy             = busy_r;
   assign done             = done_r;
   assign pass             = pass_r;
   assign err_cnt          = err_cnt_r;
   assign first_fail_valid = ff_valid_r;
   assign first_fail_idx   = ff_idx_r;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Self-checking bench: table-driven gate sweeps, random gates against a truth-table model,
// plus hand-written restart, mid-run reset, multi-pass and saturation sequences.
module tb_gate_truth_table_checker;
   import gate_chk_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, start3;
   logic [3:0] gate_tt;

   logic       dut_a, dut_b, dut_c, busy, done, pass, ffv;
   logic [7:0] err_cnt;
   logic [1:0] ffi;

   logic       a3, b3, busy3, done3, pass3, ffv3;
   logic [7:0] err3;
   logic [1:0] ffi3;

   logic       a_s, b_s, busy_s, done_s, pass_s, ffv_s;
   logic [1:0] err_s, ffi_s;

   assign dut_c = gate_tt[{dut_a, dut_b}];

   gate_truth_table_checker u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .first_fail_valid(ffv), .first_fail_idx(ffi));

   gate_truth_table_checker #(.NUM_PASSES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .dut_a(a3), .dut_b(b3), .dut_c(1'b1),
      .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
      .first_fail_valid(ffv3), .first_fail_idx(ffi3));

   gate_truth_table_checker #(.NUM_PASSES(3), .ERR_W(2)) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start3), .dut_a(a_s), .dut_b(b_s), .dut_c(1'b1),
      .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_s),
      .first_fail_valid(ffv_s), .first_fail_idx(ffi_s));

   typedef struct {
      logic [3:0] tt;
      int         err;
      int         ffv;
      int         ffi;
      int         ps;
   } vec_t;

   vec_t tbl[5];
   int   n_chk = 0;
   int   n_fail = 0;
   int   done_at, busy_cyc, vec_bad, done_cnt;

   localparam int LAT1 = 4 * 1 * (2 + 2);
   localparam int LAT3 = 4 * 3 * (2 + 2);

   task automatic check(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference: compare every vector of the gate's table against the AND expectation.
   function automatic void model(input logic [3:0] tt, output int e, output int v, output int fi);
      logic [3:0] d;
      d  = tt ^ TT_AND;
      e  = 0;
      v  = 0;
      fi = 0;
      for (int i = 0; i < 4; i++) begin
         if (d[i]) begin
            e++;
            if (v == 0) begin
               v  = 1;
               fi = i;
            end
         end
      end
   endfunction

   task automatic run_main(input logic [3:0] tt, input bit again);
      gate_tt  = tt;
      done_at  = 0;
      busy_cyc = 0;
      vec_bad  = 0;
      done_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         if (busy) begin
            busy_cyc++;
            if ({dut_a, dut_b} != 2'((n - 1) / 4)) vec_bad++;
         end
         if (done) begin
            done_cnt++;
            if (done_at == 0) done_at = n;
         end
         start = (again && n == 4);
         @(negedge clk);
      end
   endtask

   task automatic check_run(input string tag, input int e, input int v, input int fi, input int ps);
      check({tag, " done_latency"}, done_at, LAT1 + 1);
      check({tag, " busy_cycles"}, busy_cyc, LAT1);
      check({tag, " vector_seq_errors"}, vec_bad, 0);
      check({tag, " done_pulses"}, done_cnt, 1);
      check({tag, " err_cnt"}, err_cnt, e);
      check({tag, " first_fail_valid"}, ffv, v);
      if (v != 0) check({tag, " first_fail_idx"}, ffi, fi);
      check({tag, " pass"}, pass, ps);
      check({tag, " last_vector"}, {dut_a, dut_b}, 3);
   endtask

   initial begin
      int e, v, fi, d3at, dsat, b3c, bsc, d3c, dsc;
      logic [3:0] tt;

      tbl[0] = '{TT_AND,  0, 0, 0, 1};
      tbl[1] = '{TT_OR,   2, 1, 1, 0};
      tbl[2] = '{TT_XOR,  3, 1, 1, 0};
      tbl[3] = '{TT_NAND, 4, 1, 0, 0};
      tbl[4] = '{TT_NOR,  2, 1, 0, 0};

      rst_n   = 1'b0;
      start   = 1'b0;
      start3  = 1'b0;
      gate_tt = TT_AND;
      repeat (3) @(negedge clk);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset pass", pass, 0);
      check("reset err_cnt", err_cnt, 0);
      check("reset ffv", ffv, 0);
      check("reset ffi", ffi, 0);
      check("reset dut_ab", {dut_a, dut_b}, 0);
      check("reset busy3", busy3, 0);
      check("reset ab3", {a3, b3}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_main(tbl[i].tt, 1'b0);
         check_run($sformatf("table[%0d]", i), tbl[i].err, tbl[i].ffv, tbl[i].ffi, tbl[i].ps);
      end

      for (int i = 0; i < 20; i++) begin
         tt = 4'($urandom_range(0, 15));
         repeat ($urandom_range(0, 4)) @(negedge clk);
         run_main(tt, 1'b0);
         model(tt, e, v, fi);
         check_run($sformatf("rand[%0d] tt=%b", i, tt), e, v, fi, (e == 0) ? 1 : 0);
      end

      // Second start during a run must be ignored.
      run_main(TT_OR, 1'b1);
      check_run("restart_ignored", 2, 1, 1, 0);

      // Mid-run reset on a failing gate: results already nonzero, then cleared.
      gate_tt = TT_NAND;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("pre_reset err_cnt", err_cnt, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midreset busy", busy, 0);
      check("midreset done", done, 0);
      check("midreset pass", pass, 0);
      check("midreset err_cnt", err_cnt, 0);
      check("midreset ffv", ffv, 0);
      check("midreset ffi", ffi, 0);
      check("midreset dut_ab", {dut_a, dut_b}, 0);
      done_cnt = 0;
      busy_cyc = 0;
      for (int n = 0; n < 30; n++) begin
         if (done) done_cnt++;
         if (busy) busy_cyc++;
         @(negedge clk);
      end
      check("midreset no_done", done_cnt, 0);
      check("midreset stays_idle", busy_cyc, 0);
      run_main(TT_AND, 1'b0);
      check_run("after_reset", 0, 0, 0, 1);

      // Stuck-at-1 gate, three sweeps, with full-width and 2-bit counters.
      d3at = 0; dsat = 0; b3c = 0; bsc = 0; d3c = 0; dsc = 0;
      @(negedge clk);
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      for (int n = 1; n <= 70; n++) begin
         if (busy3) b3c++;
         if (busy_s) bsc++;
         if (done3) begin d3c++; if (d3at == 0) d3at = n; end
         if (done_s) begin dsc++; if (dsat == 0) dsat = n; end
         @(negedge clk);
      end
      check("stuck3 done_latency", d3at, LAT3 + 1);
      check("stuck3 busy_cycles", b3c, LAT3);
      check("stuck3 done_pulses", d3c, 1);
      check("stuck3 err_cnt", err3, 9);
      check("stuck3 ffv", ffv3, 1);
      check("stuck3 ffi", ffi3, 0);
      check("stuck3 pass", pass3, 0);
      check("stuck3 last_vector", {a3, b3}, 3);
      check("sat done_latency", dsat, LAT3 + 1);
      check("sat busy_cycles", bsc, LAT3);
      check("sat done_pulses", dsc, 1);
      check("sat err_cnt", err_s, 3);
      check("sat ffv", ffv_s, 1);
      check("sat ffi", ffi_s, 0);
      check("sat pass", pass_s, 0);
      check("sat last_vector", {a_s, b_s}, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
